fby2: RTL and testbench



---
 rtl/fby2.sv | 45 ++++
 tb/tb_fby2.sv | 108 ++++++++++
 2 files changed

// File: rtl/fby2.sv
// Divide-by-2 clock generator: q is a registered square wave at half the clk rate.
// Define FBY2_ASSERT_EN to compile in simulation-only toggle/reset checks.
module fby2 #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    output logic q
);

    logic r_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= RST_VAL;
        end else begin
            r_q <= ~r_q;
        end
    end

    assign q = r_q;

`ifdef FBY2_ASSERT_EN
    // Shadow copies of what the previous edge sampled, so each edge can check the last update.
    logic r_a_armed;
    logic r_a_rst_d;
    logic r_a_q_d;

    always_ff @(posedge clk) begin
        r_a_armed <= (r_a_armed === 1'b1) || (rst === 1'b1);
        r_a_rst_d <= rst;
        r_a_q_d   <= r_q;
        if (r_a_armed === 1'b1) begin
            if ($isunknown(r_q)) begin
                $error("fby2: q is X/Z at time %0t", $time);
            end else if (r_a_rst_d && (r_q !== RST_VAL)) begin
                $error("fby2: q=%b not RST_VAL under reset at time %0t", r_q, $time);
            end else if (!r_a_rst_d && (r_q !== ~r_a_q_d)) begin
                $error("fby2: q=%b did not toggle at time %0t", r_q, $time);
            end
        end
    end
`endif

endmodule

// File: tb/tb_fby2.sv
// Directed bench for fby2: each step drives rst, queues the expected q, checks after the edge.
module tb_fby2;

    localparam logic RV = 1'b0;

    logic clk;
    logic rst;
    logic q;

    int   tests;
    int   fails;
    logic exp_q[$];

    fby2 #(.RST_VAL(RV)) dut (
        .clk(clk),
        .rst(rst),
        .q  (q)
    );

    // First rising edge at 10ns, period 10ns.
    initial begin
        clk = 1'b0;
        #5;
        forever #5 clk = ~clk;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish, got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic step(input logic rst_v, input logic exp_v, input string tag);
        logic exp_pop;
        logic got;
        rst = rst_v;
        exp_q.push_back(exp_v);
        @(posedge clk);
        #1;
        got     = q;
        exp_pop = exp_q.pop_front();
        tests++;
        assert (got === exp_pop) else begin
            fails++;
            $error("FAIL %s t=%0t got=%b exp=%b", tag, $time, got, exp_pop);
        end
        $display("[TB] %s t=%0t rst=%b q=%b exp=%b", tag, $time, rst_v, got, exp_pop);
    endtask

    initial begin
        time  t_rise_prev;
        time  t_rise;
        tests = 0;
        fails = 0;
        rst   = 1'b1;

        // Reset held across the first edge (10ns).
        step(1'b1, RV, "reset_first_edge");

        // Free run: first edge with rst low toggles to ~RV, then alternates.
        t_rise_prev = 0;
        for (int i = 0; i < 20; i++) begin
            step(1'b0, (i % 2 == 0) ? ~RV : RV, "free_run");
            if (q === ~RV) begin
                t_rise = $time;
                if (t_rise_prev != 0) begin
                    tests++;
                    assert ((t_rise - t_rise_prev) == 20) else begin
                        fails++;
                        $error("FAIL period got=%0t exp=20", t_rise - t_rise_prev);
                    end
                end
                t_rise_prev = t_rise;
            end
        end

        // Long reset: q pinned at RV on every edge.
        for (int i = 0; i < 10; i++) begin
            step(1'b1, RV, "reset_hold");
        end

        // Release, reaching q=~RV, then a single-edge pulse.
        step(1'b0, ~RV, "release");
        step(1'b0,  RV, "release");
        step(1'b0, ~RV, "release");
        step(1'b1,  RV, "pulse_at_high");
        step(1'b0, ~RV, "resume_a");
        step(1'b0,  RV, "resume_a");
        step(1'b0, ~RV, "resume_a");

        // Reach q=RV, then pulse: q stays RV, then resumes.
        step(1'b0,  RV, "to_low");
        step(1'b1,  RV, "pulse_at_low");
        step(1'b0, ~RV, "resume_b");
        step(1'b0,  RV, "resume_b");
        step(1'b0, ~RV, "resume_b");

        tests++;
        assert (exp_q.size() == 0) else begin
            fails++;
            $error("FAIL scoreboard_drain got=%0d exp=0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
